key_stroke_gen: RTL and testbench

Synthetic keypad driver: accepts key-press requests over a valid/ready handshake and drives a clean, timed press/release waveform onto the two 16-key hex keypad vectors.
- Sits upstream of the keypad read logic, in parallel with the debounced physical key path, and is OR-combined with it at the top level.
- Used by the host/OSD key-injection path and automated boot sequences.
- Produces only glitch-free, minimum-width presses and enforced release gaps, so downstream logic never needs to filter its output.

---
 rtl/key_stroke_gen_pkg.sv | 21 ++
 rtl/key_stroke_gen.sv | 110 +++++++++++
 tb/tb_key_stroke_gen.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/key_stroke_gen_pkg.sv
// Shared keypad definitions for the synthetic key-stroke generator.
package key_stroke_gen_pkg;

  localparam int unsigned KEYS_PER_PAD = 16;
  localparam int unsigned KEY_W        = 4;

  localparam logic PAD_LEFT  = 1'b0;
  localparam logic PAD_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_e;

  // One-hot key-down vector for a single key code.
  function automatic logic [KEYS_PER_PAD-1:0] key_onehot(input logic [KEY_W-1:0] key);
    return KEYS_PER_PAD'(1) << key;
  endfunction

endpackage

// File: rtl/key_stroke_gen.sv
// Synthetic keypad driver: turns accepted stroke requests into a timed
// press / release waveform on the left or right hex keypad vector.
module key_stroke_gen
  import key_stroke_gen_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1000000,
  parameter int unsigned GAP_CYCLES  = 500000,
  parameter int unsigned CNT_W       = 21
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_pad,
  input  logic [KEY_W-1:0]        req_key,
  input  logic                    abort,
  output logic [KEYS_PER_PAD-1:0] keys_left,
  output logic [KEYS_PER_PAD-1:0] keys_right,
  output logic                    busy,
  output logic                    done
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [KEYS_PER_PAD-1:0] keys_left_q, keys_left_d;
  logic [KEYS_PER_PAD-1:0] keys_right_q, keys_right_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  // State, counter and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      keys_left_q  <= '0;
      keys_right_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      keys_left_q  <= keys_left_d;
      keys_right_q <= keys_right_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Next-state, counter and next-output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    keys_left_d  = keys_left_q;
    keys_right_d = keys_right_q;
    done_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = PRESS;
          cnt_d   = '0;
          if (req_pad == PAD_LEFT) begin
            keys_left_d = key_onehot(req_key);
          end else begin
            keys_right_d = key_onehot(req_key);
          end
        end
      end
      PRESS: begin
        // Abort coinciding with the normal end is indistinguishable from it.
        if (abort || (cnt_q == HOLD_LAST)) begin
          state_d      = GAP;
          cnt_d        = '0;
          keys_left_d  = '0;
          keys_right_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d      = IDLE;
        cnt_d        = '0;
        keys_left_d  = '0;
        keys_right_d = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Ready is a pure state decode so a request can land on the done cycle.
  assign req_ready  = (state_q == IDLE);
  assign keys_left  = keys_left_q;
  assign keys_right = keys_right_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_key_stroke_gen.sv
// Bench for key_stroke_gen: directed scenarios plus randomized traffic,
// all checked against a stroke-schedule model every cycle.
module tb_key_stroke_gen;

  localparam int unsigned HOLD = 4;
  localparam int unsigned GAPC = 3;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_pad;
  logic [3:0]  req_key;
  logic        abort;
  logic [15:0] keys_left;
  logic [15:0] keys_right;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  key_stroke_gen #(
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAPC),
    .CNT_W      (21)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_pad   (req_pad),
    .req_key   (req_key),
    .abort     (abort),
    .keys_left (keys_left),
    .keys_right(keys_right),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stroke-schedule model: a stroke accepted at the edge ending cycle acc_n
  // presses during cycles acc_n+1 .. acc_n+hold_len, is busy through
  // acc_n+hold_len+GAPC and pulses done in the cycle after that.
  int   cyc = 0;
  bit   mvalid = 1'b0;
  bit   active = 1'b0;
  int   acc_n = 0;
  int   hold_len = 0;
  logic m_pad = 1'b0;
  logic [3:0] m_key = 4'd0;

  always @(negedge clk) begin
    bit pressing, busy_e, done_e;
    logic [15:0] vec;
    cyc++;
    pressing = active && (cyc > acc_n) && (cyc <= acc_n + hold_len);
    busy_e   = active && (cyc > acc_n) && (cyc <= acc_n + hold_len + int'(GAPC));
    done_e   = active && (cyc == acc_n + hold_len + int'(GAPC) + 1);
    vec      = 16'd0;
    if (pressing) vec[m_key] = 1'b1;
    if (mvalid) begin
      chk("mon keys_left",  {16'd0, keys_left},  {16'd0, (m_pad == 1'b0) ? vec : 16'd0});
      chk("mon keys_right", {16'd0, keys_right}, {16'd0, (m_pad == 1'b1) ? vec : 16'd0});
      chk("mon busy",       {31'd0, busy},       {31'd0, busy_e});
      chk("mon done",       {31'd0, done},       {31'd0, done_e});
      chk("mon req_ready",  {31'd0, req_ready},  {31'd0, !busy_e});
    end
    // Effect of the upcoming edge.
    if (!rst_n) begin
      mvalid = 1'b1;
      active = 1'b0;
    end else if (mvalid) begin
      if (pressing && abort) begin
        hold_len = cyc - acc_n;
      end else if (!busy_e && req_valid) begin
        active   = 1'b1;
        acc_n    = cyc;
        hold_len = int'(HOLD);
        m_pad    = req_pad;
        m_key    = req_key;
      end
    end
  end

  // Waits (bounded) for ready, offers one request, returns in the first hold cycle.
  task automatic accept(input logic pad, input logic [3:0] key);
    for (int i = 0; i < 50 && !req_ready; i++) begin
      @(posedge clk); #1;
    end
    chk("accept ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_pad   = pad;
    req_key   = key;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Counts hold and gap cycles of the stroke in flight until done.
  task automatic measure(input string nm, input logic [15:0] el, input logic [15:0] er,
                         input int eh, input int eg);
    int h = 0;
    int g = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        chk({nm, " ready at done"}, {31'd0, req_ready}, 32'd1);
      end else if (keys_left != 16'd0 || keys_right != 16'd0) begin
        h++;
        chk({nm, " key vector"}, {keys_left, keys_right}, {el, er});
      end else if (busy) begin
        g++;
      end
    end
    chk({nm, " done seen"}, {31'd0, seen}, 32'd1);
    chk({nm, " hold cycles"}, h, eh);
    chk({nm, " gap cycles"}, g, eg);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2;
    rst_n = 1'b0; req_valid = 1'b0; req_pad = 1'b0; req_key = 4'd0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", {keys_left, keys_right}, 32'd0);
    chk("reset busy/done", {30'd0, busy, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready after reset", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;

    // Single stroke on the left pad.
    accept(1'b0, 4'hA);
    measure("single", 16'h0400, 16'h0000, 4, 3);

    // Back-to-back strokes with valid held.
    req_valid = 1'b1; req_pad = 1'b1; req_key = 4'h0;
    @(posedge clk); #1;
    req_key = 4'hF;
    t1 = -1; t2 = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (keys_right == 16'h0001 && t1 < 0) t1 = i;
      if (keys_right == 16'h8000 && t2 < 0) t2 = i;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("b2b first rise", t1, 0);
    chk("b2b spacing", t2 - t1, 8);
    repeat (10) @(posedge clk);
    #1;

    // Abort in the second hold cycle.
    accept(1'b0, 4'h3);
    fork
      measure("abort", 16'h0008, 16'h0000, 2, 3);
      begin
        @(posedge clk); #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
      end
    join

    // Request inputs wiggled during PRESS and GAP.
    accept(1'b1, 4'h7);
    fork
      measure("ignored", 16'h0000, 16'h0080, 4, 3);
      begin
        for (int i = 0; i < 7; i++) begin
          req_valid = 1'($urandom_range(0, 1));
          req_pad   = 1'($urandom_range(0, 1));
          req_key   = 4'($urandom_range(0, 15));
          @(posedge clk); #1;
        end
        req_valid = 1'b0;
      end
    join
    chk("ignored no extra accept", {30'd0, busy, req_ready}, 32'd1);

    // Reset in the second hold cycle.
    accept(1'b0, 4'h5);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid-stroke key before reset", {keys_left, keys_right}, {16'h0020, 16'h0000});
    @(posedge clk); #1;
    chk("mid-stroke reset keys", {keys_left, keys_right}, 32'd0);
    chk("mid-stroke reset busy/done", {30'd0, busy, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid-stroke ready after release", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;

    // Randomized traffic with occasional aborts and resets.
    for (int i = 0; i < 600; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_pad   = 1'($urandom_range(0, 1));
      req_key   = 4'($urandom_range(0, 15));
      abort     = ($urandom_range(0, 7) == 0);
      rst_n     = ($urandom_range(0, 99) != 0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1; req_valid = 1'b0; abort = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("final idle", {30'd0, busy, req_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
